// File: rtl/decoder_scan_seq.sv
// Scan sequencer for a 3-to-8 decoder: walks the addresses enabled by a
// captured mask, holding each one for dwell+1 cycles, in single-pass or
// continuous mode.
module decoder_scan_seq #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               i0,
    output logic               i1,
    output logic               i2,
    output logic               sel_valid,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         addr, addr_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [DWELL_W-1:0] dwell_r, dwell_nxt;
    logic [7:0]         mask_r, mask_nxt;
    logic               mode_r, mode_nxt;
    logic               wrap_r, wrap_nxt;
    logic [3:0]         above;

    // Index of the lowest set bit; caller guarantees the mask is non-zero.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) r = 3'(k);
        end
        return r;
    endfunction

    // {found, index} of the nearest set bit strictly above cur.
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            if (k > int'(cur) && m[k]) r = {1'b1, 3'(k)};
        end
        return r;
    endfunction

    // State, address, slot counter and captured configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= 3'd0;
            cnt     <= '0;
            dwell_r <= '0;
            mask_r  <= 8'd0;
            mode_r  <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr    <= addr_nxt;
            cnt     <= cnt_nxt;
            dwell_r <= dwell_nxt;
            mask_r  <= mask_nxt;
            mode_r  <= mode_nxt;
            wrap_r  <= wrap_nxt;
        end
    end

    assign above = next_above(mask_r, addr);

    // Next-state logic: capture on start, advance at slot ends, abort on stop.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        cnt_nxt   = cnt;
        dwell_nxt = dwell_r;
        mask_nxt  = mask_r;
        mode_nxt  = mode_r;
        wrap_nxt  = 1'b0;
        case (state)
            IDLE: begin
                addr_nxt = 3'd0;
                cnt_nxt  = '0;
                if (start && !stop && (mask != 8'd0)) begin
                    state_nxt = SCAN;
                    mask_nxt  = mask;
                    dwell_nxt = dwell;
                    mode_nxt  = mode_cont;
                    addr_nxt  = lowest_set(mask);
                end
            end
            SCAN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    addr_nxt  = 3'd0;
                    cnt_nxt   = '0;
                end else if (cnt == dwell_r) begin
                    cnt_nxt = '0;
                    if (above[3]) begin
                        addr_nxt = above[2:0];
                    end else if (mode_r) begin
                        addr_nxt = lowest_set(mask_r);
                        wrap_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        addr_nxt  = 3'd0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                addr_nxt  = 3'd0;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                addr_nxt  = 3'd0;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign i0        = addr[0];
    assign i1        = addr[1];
    assign i2        = addr[2];
    assign sel_valid = (state == SCAN);
    assign busy      = (state == SCAN);
    assign wrap      = wrap_r;
    assign done      = (state == DONE);

endmodule
